aes_keyexp_multi: RTL and testbench

- Parametrised AES key expansion supporting 128-, 192- and 256-bit keys, selected at run time.
- Computes one 32-bit schedule word per cycle using a single shared SubWord (4 S-boxes).
- Stores the full word array internally and serves 128-bit round keys through a registered random-access read port.
- Sits between the key-load logic and the AES round datapath used by FrodoKEM's AES-based matrix generation; replaces the fixed 128-bit, all-keys-in-parallel scheduler.

---
 rtl/aes_keyexp_multi_if.sv | 40 ++++
 rtl/aes_keyexp_multi.sv | 245 ++++++++++++++++++++++++
 tb/tb_aes_keyexp_multi.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_keyexp_multi_if.sv
// -----------------------------------------------------------------------------
// aes_keyexp_multi_if
// Bundles the control, key-load and round-key read signals of the AES key
// expansion block so that the key-load logic (master) and the scheduler
// (slave) connect through one port.
//
// Signals (directions seen from the scheduler):
//   i_start       in   1    start-expansion strobe
//   i_mode        in   2    key length: 0 = 128, 1 = 192, 2 = 256, 3 = illegal
//   i_key         in   256  key, MSB-first, shorter keys left-aligned
//   i_rk_idx      in   4    round-key index 0..Nr
//   o_rk          out  128  registered round key for i_rk_idx
//   o_nr          out  4    Nr of the last accepted mode
//   o_busy        out  1    expansion in progress
//   o_done        out  1    one-cycle completion pulse
//   o_keys_valid  out  1    stored schedule complete and readable
//   o_err         out  1    one-cycle pulse on a rejected start
// -----------------------------------------------------------------------------
interface aes_keyexp_multi_if;
  logic         i_start;
  logic [1:0]   i_mode;
  logic [255:0] i_key;
  logic [3:0]   i_rk_idx;
  logic [127:0] o_rk;
  logic [3:0]   o_nr;
  logic         o_busy;
  logic         o_done;
  logic         o_keys_valid;
  logic         o_err;

  modport master (
    output i_start, i_mode, i_key, i_rk_idx,
    input  o_rk, o_nr, o_busy, o_done, o_keys_valid, o_err
  );

  modport slave (
    input  i_start, i_mode, i_key, i_rk_idx,
    output o_rk, o_nr, o_busy, o_done, o_keys_valid, o_err
  );
endinterface

// File: rtl/aes_keyexp_multi.sv
// -----------------------------------------------------------------------------
// aes_keyexp_multi
// Run-time selectable AES-128/192/256 key expansion. One 32-bit schedule word
// is produced per cycle through a single shared SubWord (four S-boxes). The
// complete word array is kept locally and 128-bit round keys are served from a
// registered random-access read port.
//
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high reset
//   bus     aes_keyexp_multi_if.slave: start/mode/key in, round-key read port,
//           status (o_nr, o_busy, o_done, o_keys_valid, o_err) out
//
// Parameters:
//   EN_192, EN_256  enable the 192-/256-bit modes; a disabled mode is rejected
//                   like mode 3 and its schedule logic becomes constant.
//   MAX_WORDS       word-array depth; must cover 44/52/60 words for the
//                   largest enabled mode and must not exceed 64.
// -----------------------------------------------------------------------------
module aes_keyexp_multi #(
  parameter bit EN_192    = 1'b1,
  parameter bit EN_256    = 1'b1,
  parameter int MAX_WORDS = 60
) (
  input logic              i_clk,
  input logic              i_rst,
  aes_keyexp_multi_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  // FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = 11'd2040 - {x, 3'b000};
    return SBOX_TBL[base +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Multiply by x in GF(2^8); walks Rcon 01,02,...,80,1b,36.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  logic [31:0]  w_q [MAX_WORDS];

  state_e       state_q, state_d;
  logic [5:0]   i_q, i_d;         // index of the word being produced
  logic [2:0]   j_q, j_d;         // i mod Nk, tracked incrementally
  logic [3:0]   nk_q, nk_d;
  logic [5:0]   last_q, last_d;   // Nw - 1
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   nr_q, nr_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [127:0] rk_q, rk_d;

  logic         load_s;
  logic         wr_s;
  logic         mode_ok_s;
  logic [3:0]   nk_sel_s;
  logic [3:0]   nr_sel_s;
  logic [31:0]  prev_s;
  logic [31:0]  back_s;
  logic [31:0]  sub_out_s;
  logic [31:0]  temp_s;
  logic [31:0]  new_word_s;

  // Decode the requested key length and whether this build accepts it.
  always_comb begin
    nk_sel_s  = 4'd4;
    nr_sel_s  = 4'd10;
    mode_ok_s = 1'b0;
    case (bus.i_mode)
      2'd0: begin nk_sel_s = 4'd4; nr_sel_s = 4'd10; mode_ok_s = 1'b1;   end
      2'd1: begin nk_sel_s = 4'd6; nr_sel_s = 4'd12; mode_ok_s = EN_192; end
      2'd2: begin nk_sel_s = 4'd8; nr_sel_s = 4'd14; mode_ok_s = EN_256; end
      default: begin nk_sel_s = 4'd4; nr_sel_s = 4'd10; mode_ok_s = 1'b0; end
    endcase
  end

  // One schedule word: the single SubWord sees RotWord(w[i-1]) at a group
  // boundary and plain w[i-1] at the 256-bit mid-group step.
  always_comb begin
    prev_s    = w_q[i_q - 6'd1];
    back_s    = w_q[i_q - {2'b00, nk_q}];
    sub_out_s = sub_word((j_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s);
    if (j_q == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_q, 24'h000000};
    end else if ((nk_q == 4'd8) && (j_q == 3'd4)) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = prev_s;
    end
    new_word_s = back_s ^ temp_s;
  end

  // Next-state and output logic of the IDLE/EXPAND/DONE controller.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    nk_d    = nk_q;
    last_d  = last_q;
    rcon_d  = rcon_q;
    nr_d    = nr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    err_d   = 1'b0;
    load_s  = 1'b0;
    wr_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start && mode_ok_s) begin
          load_s  = 1'b1;
          i_d     = {2'b00, nk_sel_s};
          j_d     = 3'd0;
          nk_d    = nk_sel_s;
          last_d  = {nr_sel_s, 2'b11};   // 4*Nr + 3 = Nw - 1
          rcon_d  = 8'h01;
          nr_d    = nr_sel_s;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = EXPAND;
        end else if (bus.i_start) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      EXPAND: begin
        wr_s = 1'b1;
        i_d  = i_q + 6'd1;
        if ({1'b0, j_q} == (nk_q - 4'd1)) begin
          j_d = 3'd0;
        end else begin
          j_d = j_q + 3'd1;
        end
        if (j_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end else begin
          rcon_d = rcon_q;
        end
        if (i_q == last_q) begin
          state_d = DONE;
        end else begin
          state_d = EXPAND;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Round-key read mux; indices past Nr read as zero.
  always_comb begin
    rk_d = 128'h0;
    if (bus.i_rk_idx <= nr_q) begin
      rk_d = {w_q[{bus.i_rk_idx, 2'b00}], w_q[{bus.i_rk_idx, 2'b01}],
              w_q[{bus.i_rk_idx, 2'b10}], w_q[{bus.i_rk_idx, 2'b11}]};
    end else begin
      rk_d = 128'h0;
    end
  end

  // Controller, status and read-port registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      i_q     <= 6'd0;
      j_q     <= 3'd0;
      nk_q    <= 4'd4;
      last_q  <= 6'd43;
      rcon_q  <= 8'h01;
      nr_q    <= 4'd10;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rk_q    <= 128'h0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      nk_q    <= nk_d;
      last_q  <= last_d;
      rcon_q  <= rcon_d;
      nr_q    <= nr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rk_q    <= rk_d;
    end
  end

  // Word array: no reset. A start loads all eight key words; the ones beyond
  // Nk are overwritten by the expansion before the schedule becomes valid.
  always_ff @(posedge i_clk) begin
    if (load_s) begin
      for (int k = 0; k < 8; k++) begin
        w_q[6'(k)] <= bus.i_key[8'(255 - 32 * k) -: 32];
      end
    end else if (wr_s) begin
      w_q[i_q] <= new_word_s;
    end
  end

  assign bus.o_rk         = rk_q;
  assign bus.o_nr         = nr_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_keys_valid = valid_q;
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_aes_keyexp_multi.sv
// -----------------------------------------------------------------------------
// tb_aes_keyexp_multi
// Directed FIPS-197 key-expansion vectors. Stimulus pushes expected completion
// cycles, error pulses and round-key reads into queues; a negedge monitor pops
// and compares whenever the DUT presents o_done, o_err or a read result.
// A second instance with EN_256 = 0 covers the disabled-mode rejection.
// -----------------------------------------------------------------------------
module tb_aes_keyexp_multi;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'h0123456789abcdef0123456789abcdef};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                   64'hffffffffffffffff};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_keyexp_multi_if bus ();
  aes_keyexp_multi_if bus2 ();

  aes_keyexp_multi #(.EN_192(1'b1), .EN_256(1'b1), .MAX_WORDS(60)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  aes_keyexp_multi #(.EN_192(1'b1), .EN_256(1'b0), .MAX_WORDS(52)) dut2 (
    .i_clk(clk), .i_rst(rst), .bus(bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int st_cyc = 0;
  logic rd_flag = 1'b0;
  logic rd_pend = 1'b0;

  int           done_exp [$];
  int           err_exp  [$];
  int           err2_exp [$];
  logic [127:0] rd_val   [$];
  logic         rd_sel   [$];
  string        rd_name  [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cycle counter and read-result pipeline (result visible one edge later).
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_flag;
  end

  // Monitor: pop and compare whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (bus.o_done === 1'b1) begin
      if (done_exp.size() == 0) chk("unexpected_done", 128'd1, 128'd0);
      else chk("done_cycle", 128'(cyc), 128'(done_exp.pop_front()));
    end
    if (bus.o_err === 1'b1) begin
      if (err_exp.size() == 0) chk("unexpected_err", 128'd1, 128'd0);
      else chk("err_cycle", 128'(cyc), 128'(err_exp.pop_front()));
    end
    if (bus2.o_err === 1'b1) begin
      if (err2_exp.size() == 0) chk("unexpected_err2", 128'd1, 128'd0);
      else chk("err2_cycle", 128'(cyc), 128'(err2_exp.pop_front()));
    end
    if (rd_pend) begin
      if (rd_val.size() == 0) begin
        chk("read_underflow", 128'd1, 128'd0);
      end else begin
        logic s;
        s = rd_sel.pop_front();
        chk(rd_name.pop_front(), s ? bus2.o_rk : bus.o_rk, rd_val.pop_front());
      end
    end
  end

  task automatic start(input bit sel, input bit now, input logic [1:0] m, input logic [255:0] key);
    if (!now) @(negedge clk);
    if (sel) begin bus2.i_mode = m; bus2.i_key = key; bus2.i_start = 1'b1; end
    else     begin bus.i_mode  = m; bus.i_key  = key; bus.i_start  = 1'b1; end
    @(posedge clk);
    #1;
    bus.i_start  = 1'b0;
    bus2.i_start = 1'b0;
    st_cyc = cyc;
  endtask

  task automatic wait_done(input bit sel, input int max_c, input string name);
    int k;
    k = 0;
    while (((sel ? bus2.o_done : bus.o_done) !== 1'b1) && (k < max_c)) begin
      @(negedge clk);
      k++;
    end
    if ((sel ? bus2.o_done : bus.o_done) !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, o_done never rose", name, k);
    end
  endtask

  task automatic rd(input bit sel, input logic [3:0] idx, input logic [127:0] exp, input string name);
    @(negedge clk);
    if (sel) bus2.i_rk_idx = idx;
    else     bus.i_rk_idx  = idx;
    rd_val.push_back(exp);
    rd_sel.push_back(sel);
    rd_name.push_back(name);
    rd_flag = 1'b1;
    @(posedge clk);
    #1;
    rd_flag = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  128'(bus.o_busy),       128'd0);
    chk({tag, "_done"},  128'(bus.o_done),       128'd0);
    chk({tag, "_valid"}, 128'(bus.o_keys_valid), 128'd0);
    chk({tag, "_err"},   128'(bus.o_err),        128'd0);
    chk({tag, "_rk"},    bus.o_rk,               128'd0);
    chk({tag, "_nr"},    128'(bus.o_nr),         128'd10);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;  bus.i_mode = 2'd0;  bus.i_key = 256'h0;  bus.i_rk_idx = 4'd0;
    bus2.i_start = 1'b0; bus2.i_mode = 2'd0; bus2.i_key = 256'h0; bus2.i_rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 128-bit run with a stray start at cycle 20 that must be ignored.
    start(1'b0, 1'b0, 2'd0, K128);
    done_exp.push_back(st_cyc + 41);
    repeat (19) @(negedge clk);
    bus.i_mode = 2'd2; bus.i_key = K256; bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    wait_done(1'b0, 60, "done_128");
    chk("nr_128", 128'(bus.o_nr), 128'd10);
    chk("valid_128", 128'(bus.o_keys_valid), 128'd1);
    chk("busy_128", 128'(bus.o_busy), 128'd0);
    rd(1'b0, 4'd0,  RK128_0,  "rk128_0");
    rd(1'b0, 4'd1,  RK128_1,  "rk128_1");
    rd(1'b0, 4'd10, RK128_10, "rk128_10");
    rd(1'b0, 4'd11, 128'h0,   "rk128_11_zero");

    // 256-bit run.
    start(1'b0, 1'b0, 2'd2, K256);
    done_exp.push_back(st_cyc + 53);
    wait_done(1'b0, 70, "done_256");
    chk("nr_256", 128'(bus.o_nr), 128'd14);
    rd(1'b0, 4'd1,  RK256_1,  "rk256_1");
    rd(1'b0, 4'd14, RK256_14, "rk256_14");
    rd(1'b0, 4'd15, 128'h0,   "rk256_15_zero");

    // 128-bit run, then a 192-bit start while o_done is high.
    start(1'b0, 1'b0, 2'd0, K128);
    done_exp.push_back(st_cyc + 41);
    wait_done(1'b0, 60, "done_128b");
    start(1'b0, 1'b1, 2'd1, K192);
    done_exp.push_back(st_cyc + 47);
    chk("b2b_busy", 128'(bus.o_busy), 128'd1);
    chk("b2b_valid", 128'(bus.o_keys_valid), 128'd0);
    wait_done(1'b0, 60, "done_192");
    chk("nr_192", 128'(bus.o_nr), 128'd12);
    rd(1'b0, 4'd0,  RK192_0,  "rk192_0");
    rd(1'b0, 4'd12, RK192_12, "rk192_12");
    rd(1'b0, 4'd13, 128'h0,   "rk192_13_zero");

    // Illegal mode 3: one error pulse, schedule retained.
    start(1'b0, 1'b0, 2'd3, K256);
    err_exp.push_back(st_cyc);
    repeat (3) @(negedge clk);
    chk("ill_valid", 128'(bus.o_keys_valid), 128'd1);
    chk("ill_busy", 128'(bus.o_busy), 128'd0);
    chk("ill_nr", 128'(bus.o_nr), 128'd12);
    rd(1'b0, 4'd12, RK192_12, "ill_rk192_12");

    // Instance without 256-bit support: mode 2 is rejected.
    start(1'b1, 1'b0, 2'd1, K192);
    wait_done(1'b1, 60, "dut2_done_192");
    chk("dut2_done_cycle", 128'(cyc), 128'(st_cyc + 47));
    start(1'b1, 1'b0, 2'd2, K256);
    err2_exp.push_back(st_cyc);
    repeat (3) @(negedge clk);
    chk("dut2_valid", 128'(bus2.o_keys_valid), 128'd1);
    chk("dut2_busy", 128'(bus2.o_busy), 128'd0);
    chk("dut2_nr", 128'(bus2.o_nr), 128'd12);
    rd(1'b1, 4'd12, RK192_12, "dut2_rk192_12");

    // Asynchronous reset in the middle of a 256-bit run.
    start(1'b0, 1'b0, 2'd2, K256);
    repeat (14) @(negedge clk);
    chk("pre_reset_busy", 128'(bus.o_busy), 128'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;

    // Fresh 128-bit run after reset.
    start(1'b0, 1'b0, 2'd0, K128);
    done_exp.push_back(st_cyc + 41);
    wait_done(1'b0, 60, "done_128_post_reset");
    chk("nr_post_reset", 128'(bus.o_nr), 128'd10);
    rd(1'b0, 4'd10, RK128_10, "post_reset_rk128_10");

    repeat (3) @(negedge clk);
    chk("leftover_done", 128'(done_exp.size()), 128'd0);
    chk("leftover_err", 128'(err_exp.size() + err2_exp.size()), 128'd0);
    chk("leftover_rd", 128'(rd_val.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
